// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the two-port register-file write arbiter.
// Holds the FSM encoding, register index names and datapath widths.
package regfile_write_arbiter_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 4;

  localparam logic [ADDR_W-1:0] REG_A = 2'd0;
  localparam logic [ADDR_W-1:0] REG_B = 2'd1;
  localparam logic [ADDR_W-1:0] REG_C = 2'd2;
  localparam logic [ADDR_W-1:0] REG_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_ACK   = 2'b10
  } state_e;

  typedef enum logic {
    PORT_ALU = 1'b0,
    PORT_LD  = 1'b1
  } port_e;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  function automatic logic [NUM_REGS-1:0] dest_onehot(input logic [ADDR_W-1:0] dest);
    dest_onehot       = '0;
    dest_onehot[dest] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_req_buffer.sv
// Single-entry holding buffer for one requester; ready is simply "not full".
// The arbiter clears the entry on the edge that ends its ISSUE cycle.
module regfile_req_buffer
  import regfile_write_arbiter_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_valid,
  output logic    o_ready,
  input  wr_req_t i_req,
  input  logic    i_clr,
  output logic    o_full,
  output wr_req_t o_req,
  output logic    o_capture
);

  logic    r_full;
  wr_req_t r_req;
  logic    w_capture;

  assign w_capture = i_valid & ~r_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= 1'b0;
    end else if (w_capture) begin
      r_full <= 1'b1;
    end else if (i_clr) begin
      r_full <= 1'b0;
    end
  end

  // NOTE: the payload has no reset; it is meaningless unless r_full is set,
  // so resetting it would only add reset fan-out.
  always_ff @(posedge i_clk) begin
    if (w_capture) begin
      r_req <= i_req;
    end
  end

  assign o_ready   = ~r_full;
  assign o_full    = r_full;
  assign o_req     = r_req;
  assign o_capture = w_capture;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load-unit writes onto a single register-file write port,
// keeping per-register write order and flagging missing acknowledges.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_alu_valid,
  output logic                o_alu_ready,
  input  logic [ADDR_W-1:0]   i_alu_dest,
  input  logic [DATA_W-1:0]   i_alu_data,
  input  logic                i_ld_valid,
  output logic                o_ld_ready,
  input  logic [ADDR_W-1:0]   i_ld_dest,
  input  logic [DATA_W-1:0]   i_ld_data,
  output logic                o_wr_enable,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [DATA_W-1:0]   o_wr_data,
  input  logic                i_wr_done,
  output logic [NUM_REGS-1:0] o_pending,
  output logic                o_ack_error
);

  localparam logic [3:0] LP_ACK_LAST = 4'(ACK_TIMEOUT - 1);

  state_e            r_state;
  port_e             r_winner;
  port_e             r_rr_ptr;
  logic              r_alu_age;
  logic              r_ld_age;
  logic [3:0]        r_ack_cnt;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_ack_error;

  wr_req_t w_alu_in, w_ld_in, w_alu_req, w_ld_req, w_grant_req;
  logic    w_alu_full, w_ld_full, w_alu_cap, w_ld_cap, w_alu_clr, w_ld_clr;
  logic    w_grant_valid, w_launch;
  port_e   w_winner;

  assign w_alu_in  = '{dest: i_alu_dest, data: i_alu_data};
  assign w_ld_in   = '{dest: i_ld_dest,  data: i_ld_data};
  assign w_alu_clr = (r_state == ST_ISSUE) && (r_winner == PORT_ALU);
  assign w_ld_clr  = (r_state == ST_ISSUE) && (r_winner == PORT_LD);

  regfile_req_buffer u_alu_buf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_alu_valid),
    .o_ready   (o_alu_ready),
    .i_req     (w_alu_in),
    .i_clr     (w_alu_clr),
    .o_full    (w_alu_full),
    .o_req     (w_alu_req),
    .o_capture (w_alu_cap)
  );

  regfile_req_buffer u_ld_buf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_ld_valid),
    .o_ready   (o_ld_ready),
    .i_req     (w_ld_in),
    .i_clr     (w_ld_clr),
    .o_full    (w_ld_full),
    .o_req     (w_ld_req),
    .o_capture (w_ld_cap)
  );

  // Age bit marks the younger entry; it drops once the other buffer drains so
  // two resident entries can never both claim to be younger.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alu_age <= 1'b0;
      r_ld_age  <= 1'b0;
    end else begin
      if (w_alu_clr)     r_alu_age <= 1'b0;
      else if (w_alu_cap) r_alu_age <= w_ld_full & ~w_ld_clr;
      else if (w_ld_clr)  r_alu_age <= 1'b0;

      if (w_ld_clr)      r_ld_age <= 1'b0;
      else if (w_ld_cap)  r_ld_age <= w_alu_full & ~w_alu_clr;
      else if (w_alu_clr) r_ld_age <= 1'b0;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    w_grant_valid = w_alu_full | w_ld_full;
    w_winner      = PORT_ALU;
    if (w_alu_full && w_ld_full) begin
      if (w_alu_req.dest == w_ld_req.dest) begin
        w_winner = (r_alu_age && !r_ld_age) ? PORT_LD : PORT_ALU;
      end else begin
        w_winner = r_rr_ptr;
      end
    end else if (w_ld_full) begin
      w_winner = PORT_LD;
    end
    w_grant_req = (w_winner == PORT_ALU) ? w_alu_req : w_ld_req;
  end

  // An acknowledged ACK launches the next grant directly, giving one write
  // every two cycles under back-to-back load.
  assign w_launch = w_grant_valid &&
                    ((r_state == ST_IDLE) || ((r_state == ST_ACK) && i_wr_done));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_winner    <= PORT_ALU;
      r_rr_ptr    <= PORT_ALU;
      r_ack_cnt   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= REG_A;
      r_wr_data   <= '0;
      r_ack_error <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_launch) begin
        r_state   <= ST_ISSUE;
        r_wr_en   <= 1'b1;
        r_wr_addr <= w_grant_req.dest;
        r_wr_data <= w_grant_req.data;
        r_winner  <= w_winner;
        r_rr_ptr  <= (w_winner == PORT_ALU) ? PORT_LD : PORT_ALU;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_IDLE;
          ST_ISSUE: begin
            r_state   <= ST_ACK;
            r_ack_cnt <= '0;
          end
          ST_ACK: begin
            if (i_wr_done) begin
              r_state <= ST_IDLE;
            end else if (r_ack_cnt == LP_ACK_LAST) begin
              r_ack_error <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_ack_cnt <= r_ack_cnt + 4'd1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    o_pending = '0;
    if (w_alu_full)          o_pending = o_pending | dest_onehot(w_alu_req.dest);
    if (w_ld_full)           o_pending = o_pending | dest_onehot(w_ld_req.dest);
    if (r_state != ST_IDLE)  o_pending = o_pending | dest_onehot(r_wr_addr);
  end

  assign o_wr_enable = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_ack_error = r_ack_error;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: per-register ordered scoreboard fed by the drivers,
// checked by a monitor on every write strobe, plus directed timing checks.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, ld_valid = 1'b0;
  logic        alu_ready, ld_ready;
  logic [1:0]  alu_dest = '0, ld_dest = '0;
  logic [15:0] alu_data = '0, ld_data = '0;
  logic        wr_enable;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_done = 1'b0;
  logic [3:0]  pending;
  logic        ack_error;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.ACK_TIMEOUT(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_alu_valid (alu_valid),
    .o_alu_ready (alu_ready),
    .i_alu_dest  (alu_dest),
    .i_alu_data  (alu_data),
    .i_ld_valid  (ld_valid),
    .o_ld_ready  (ld_ready),
    .i_ld_dest   (ld_dest),
    .i_ld_data   (ld_data),
    .o_wr_enable (wr_enable),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .i_wr_done   (wr_done),
    .o_pending   (pending),
    .o_ack_error (ack_error)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: writes to one register retire in acceptance order,
  // simultaneous acceptance counting the ALU as older.
  typedef struct {
    int          cyc;
    bit          port;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[4][$];
  logic [15:0] rf_model[4];
  int          obs_addr[$];
  int          obs_cyc[$];
  int          n_writes  = 0;
  int          done_mode = 1;  // 0: never ack, 1: always ack, 2: random ack
  bit          prev_we   = 1'b0;

  task automatic push_exp(input logic [1:0] dest, input bit port, input logic [15:0] data);
    exp_t e;
    int   i;
    e.cyc  = cyc;
    e.port = port;
    e.data = data;
    i = exp_q[dest].size();
    while (i > 0 && (exp_q[dest][i-1].cyc > e.cyc ||
                     (exp_q[dest][i-1].cyc == e.cyc && exp_q[dest][i-1].port > e.port)))
      i--;
    exp_q[dest].insert(i, e);
  endtask

  function automatic int sb_count();
    int n = 0;
    for (int r = 0; r < 4; r++) n += exp_q[r].size();
    return n;
  endfunction

  task automatic flush_model();
    for (int r = 0; r < 4; r++) exp_q[r].delete();
  endtask

  // Monitor and register-file acknowledge responder.
  initial begin
    exp_t e;
    for (int r = 0; r < 4; r++) rf_model[r] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wr_done = 1'b0;
        prev_we = 1'b0;
      end else begin
        wr_done = prev_we && (done_mode == 1 ||
                              (done_mode == 2 && $urandom_range(0, 7) != 0));
        prev_we = wr_enable;
        if (wr_enable) begin
          n_writes++;
          obs_addr.push_back(int'(wr_addr));
          obs_cyc.push_back(cyc);
          rf_model[wr_addr] = wr_data;
          check("sb_has_entry", 32'(exp_q[wr_addr].size() > 0), 1);
          if (exp_q[wr_addr].size() > 0) begin
            e = exp_q[wr_addr].pop_front();
            check("sb_write_data", wr_data, e.data);
          end
        end
      end
    end
  end

  task automatic send(input bit port, input logic [1:0] dest, input logic [15:0] data);
    int guard = 0;
    if (port == 1'b0) begin
      alu_valid = 1'b1; alu_dest = dest; alu_data = data;
    end else begin
      ld_valid = 1'b1; ld_dest = dest; ld_data = data;
    end
    while (!(port ? ld_ready : alu_ready) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("send_accepted", 32'(guard < 200), 1);
    push_exp(dest, port, data);
    @(negedge clk);
    if (port == 1'b0) alu_valid = 1'b0;
    else              ld_valid  = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((sb_count() != 0 || pending != 4'b0000) && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("drain_done", 32'(g < 200), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, w0, nw;

    // Reset values
    @(negedge clk);
    check("rst_alu_ready", alu_ready, 1);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_wr_enable", wr_enable, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_pending", pending, 0);
    check("rst_ack_error", ack_error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single ALU write and its exact timing
    send(1'b0, REG_C, 16'hBEEF);
    check("a_pending_idle", pending, 4'b0100);
    check("a_we_idle", wr_enable, 0);
    @(negedge clk);
    check("a_we_issue", wr_enable, 1);
    check("a_addr_issue", wr_addr, 2);
    check("a_data_issue", wr_data, 16'hBEEF);
    check("a_ready_issue", alu_ready, 0);
    @(negedge clk);
    check("a_we_ack", wr_enable, 0);
    check("a_pending_ack", pending, 4'b0100);
    check("a_ready_ack", alu_ready, 1);
    check("a_data_hold", wr_data, 16'hBEEF);
    @(negedge clk);
    check("a_pending_done", pending, 0);
    drain();

    // Same-destination tie: ALU first, then LD
    fork
      send(1'b0, REG_B, 16'h0001);
      send(1'b1, REG_B, 16'h0002);
    join
    drain();
    check("b_final_regB", rf_model[1], 16'h0002);

    // Continuous different-destination traffic alternates every 2 cycles
    do_reset();
    base = obs_addr.size();
    fork
      for (int i = 0; i < 6; i++) send(1'b0, REG_A, 16'hA000 + 16'(i));
      for (int i = 0; i < 6; i++) send(1'b1, REG_D, 16'hB000 + 16'(i));
    join
    drain();
    nw = obs_addr.size() - base;
    check("c_write_count", nw, 12);
    for (int k = 0; k < 12 && k < nw; k++) begin
      check("c_alternate", obs_addr[base+k], (k % 2 == 0) ? 0 : 3);
      if (k > 0) check("c_spacing", obs_cyc[base+k] - obs_cyc[base+k-1], 2);
    end

    // LD blocked behind an ALU grant keeps its data and issues next
    do_reset();
    base = obs_addr.size();
    fork
      send(1'b0, REG_A, 16'h1111);
      begin
        send(1'b1, REG_B, 16'h2222);
        send(1'b1, REG_B, 16'h3333);
      end
      begin
        @(negedge clk);
        check("d_ld_ready_full", ld_ready, 0);
        check("d_pending_both", pending, 4'b0011);
        @(negedge clk);
        check("d_ld_ready_issue", ld_ready, 0);
        check("d_addr_issue", wr_addr, 0);
        @(negedge clk);
        check("d_ld_ready_ack", ld_ready, 0);
        check("d_alu_ready_ack", alu_ready, 1);
      end
    join
    drain();
    check("d_second_write", obs_addr[base+1], 1);
    check("d_final_regB", rf_model[1], 16'h3333);

    // Acknowledge timeout
    done_mode = 0;
    send(1'b0, REG_D, 16'hDEAD);
    check("e_we_idle", wr_enable, 0);
    @(negedge clk);
    check("e_we_issue", wr_enable, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("e_no_error_in_ack", ack_error, 0);
    end
    @(negedge clk);
    check("e_ack_error_set", ack_error, 1);
    check("e_pending_clear", pending, 0);
    done_mode = 1;
    send(1'b1, REG_C, 16'h4242);
    drain();
    check("e_next_serviced", rf_model[2], 16'h4242);
    check("e_error_sticky", ack_error, 1);

    // Reset during ACK with both buffers full
    done_mode = 0;
    fork
      begin
        send(1'b0, REG_C, 16'h5555);
        send(1'b0, REG_C, 16'h6666);
      end
      send(1'b1, REG_D, 16'h7777);
    join
    check("f_pending_before", pending, 4'b1100);
    rst_n = 1'b0;
    flush_model();
    #1;
    check("f_alu_ready", alu_ready, 1);
    check("f_ld_ready", ld_ready, 1);
    check("f_wr_enable", wr_enable, 0);
    check("f_wr_addr", wr_addr, 0);
    check("f_wr_data", wr_data, 0);
    check("f_pending", pending, 0);
    check("f_ack_error", ack_error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_mode = 1;
    w0 = n_writes;
    repeat (10) @(negedge clk);
    check("f_no_write_after_rst", n_writes - w0, 0);
    check("f_pending_after_rst", pending, 0);

    // Randomized traffic against the ordered model
    do_reset();
    done_mode = 2;
    w0 = n_writes;
    fork
      for (int i = 0; i < 120; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(1'b0, 2'($urandom_range(0, 3)), 16'($urandom));
      end
      for (int i = 0; i < 120; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(1'b1, 2'($urandom_range(0, 3)), 16'($urandom));
      end
    join
    drain();
    check("r_write_count", n_writes - w0, 240);
    check("r_model_empty", sb_count(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
